imem_loader: RTL and testbench

Byte-stream boot loader that writes a program image into the instruction memory before the MIPS core runs. It accepts bytes over a valid/ready handshake, checks a 4-byte word-count header, and assembles big-endian 32-bit instruction words. It issues one write strobe per word at consecutive word-aligned byte addresses, and holds the core stalled until the image is in place. It is the write-side counterpart of the instruction memory's read port.

---
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream boot loader: header, big-endian words, one write strobe per word.
// Optional trailer checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH_WORDS = 512
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic        MemWrite,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  localparam int IW = $clog2(DEPTH_WORDS) + 1;
  localparam logic [IW-1:0] ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [23:0]   shift;
  logic [IW-1:0] index;
  logic [IW-1:0] n_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   sum;
`endif

  logic [31:0] word;
  logic        take;
  logic        last;

  // Incoming byte completes the word being shifted in, MSB first
  assign word = {shift, ByteIn};
  assign take = ByteValid & ByteReady;
  assign last = take & (byte_cnt == 2'd3);

  // Loader FSM with registered outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      byte_cnt     <= 2'd0;
      shift        <= 24'd0;
      index        <= '0;
      n_words      <= '0;
      ByteReady    <= 1'b0;
      WriteAddress <= 32'd0;
      WriteData    <= 32'd0;
      MemWrite     <= 1'b0;
      CpuHold      <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum          <= 32'd0;
`endif
    end else begin
      MemWrite <= 1'b0;
      if (take) begin
        shift    <= word[23:0];
        byte_cnt <= byte_cnt + 2'd1;
      end
      case (state)
        IDLE, DONE, ERR: begin
          if (Start) begin
            state     <= HDR;
            ByteReady <= 1'b1;
            CpuHold   <= 1'b1;
            Done      <= 1'b0;
            Error     <= 1'b0;
            index     <= '0;
            byte_cnt  <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= 32'd0;
`endif
          end
        end
        HDR: begin
          if (last) begin
            if (word == 32'd0) begin
              state     <= DONE;
              ByteReady <= 1'b0;
              CpuHold   <= 1'b0;
              Done      <= 1'b1;
            end else if (word > 32'(DEPTH_WORDS)) begin
              state     <= ERR;
              ByteReady <= 1'b0;
              CpuHold   <= 1'b0;
              Error     <= 1'b1;
            end else begin
              state   <= DATA;
              n_words <= word[IW-1:0];
            end
          end
        end
        DATA: begin
          if (last) begin
            state        <= WRITE;
            ByteReady    <= 1'b0;
            MemWrite     <= 1'b1;
            WriteData    <= word;
            WriteAddress <= {{(30-IW){1'b0}}, index, 2'b00};
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= sum + word;
`endif
          end
        end
        WRITE: begin
          index <= index + ONE;
          if (index + ONE == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state     <= CHK;
            ByteReady <= 1'b1;
`else
            state     <= DONE;
            CpuHold   <= 1'b0;
            Done      <= 1'b1;
`endif
          end else begin
            state     <= DATA;
            ByteReady <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (last) begin
            ByteReady <= 1'b0;
            CpuHold   <= 1'b0;
            if (word == sum) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              state <= ERR;
              Error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state     <= IDLE;
          ByteReady <= 1'b0;
          CpuHold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares on every MemWrite strobe.
module tb_imem_loader;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  ByteIn = 8'd0;
  logic        ByteValid = 1'b0;
  logic        ByteReady;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  compared = 0;
  int  mismatched = 0;

  imem_loader #(.DEPTH_WORDS(512)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Start(Start),
    .ByteIn(ByteIn),
    .ByteValid(ByteValid),
    .ByteReady(ByteReady),
    .WriteAddress(WriteAddress),
    .WriteData(WriteData),
    .MemWrite(MemWrite),
    .CpuHold(CpuHold),
    .Done(Done),
    .Error(Error)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard
  always @(negedge Clk) begin
    if (MemWrite) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", WriteAddress, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", WriteAddress, e.a);
        check("wr_data", WriteData, e.d);
      end
      check("rdy_in_write", 32'(ByteReady), 32'd0);
    end
  end

  task automatic send(input logic [7:0] b, input bit stall);
    bit acc;
    acc = 1'b0;
    if (stall) begin
      @(negedge Clk);
      ByteValid = 1'b0;
    end
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge Clk);
      ByteValid = 1'b1;
      ByteIn = b;
      acc = ByteReady;
      @(posedge Clk);
      #1;
    end
    ByteValid = 1'b0;
    if (!acc) check("byte_timeout", 32'(b), 32'hFFFF_FFFF);
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    send(w[31:24], stall);
    send(w[23:16], stall);
    send(w[15:8], stall);
    send(w[7:0], stall);
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic finish(input bit ok, input bit after_data);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (after_data) begin
      @(negedge Clk);
      check("last_strobe", 32'(MemWrite), 32'd1);
    end
`endif
    @(negedge Clk);
    check("end_done", 32'(Done), 32'(ok));
    check("end_error", 32'(Error), 32'(!ok));
    check("end_hold", 32'(CpuHold), 32'd0);
    check("end_rdy", 32'(ByteReady), 32'd0);
  endtask

  task automatic load2(input bit stall);
    exp_q.push_back('{32'h0000_0000, 32'h2008_0005});
    exp_q.push_back('{32'h0000_0004, 32'hAC08_0000});
    send_word(32'h0000_0002, stall);
    send_word(32'h2008_0005, stall);
    send_word(32'hAC08_0000, stall);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'hCC10_0005, stall);
`endif
    finish(1'b1, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("rst_rdy", 32'(ByteReady), 32'd0);
    check("rst_wr", 32'(MemWrite), 32'd0);
    check("rst_hold", 32'(CpuHold), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_err", 32'(Error), 32'd0);
    check("rst_addr", WriteAddress, 32'd0);
    check("rst_data", WriteData, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    pulse_start();
    check("start_rdy", 32'(ByteReady), 32'd1);
    check("start_hold", 32'(CpuHold), 32'd1);
    load2(1'b0);

`ifndef IMEM_LOADER_CHECKSUM_EN
    ByteValid = 1'b1;
    repeat (3) @(negedge Clk);
    check("post_image_rdy", 32'(ByteReady), 32'd0);
    ByteValid = 1'b0;
`endif

    pulse_start();
    check("restart_clr_done", 32'(Done), 32'd0);
    check("restart_hold", 32'(CpuHold), 32'd1);
    load2(1'b1);

    pulse_start();
    send_word(32'h0000_0000, 1'b0);
    finish(1'b1, 1'b0);

    pulse_start();
    send_word(32'h0000_0201, 1'b0);
    finish(1'b0, 1'b0);
    ByteValid = 1'b1;
    repeat (3) @(negedge Clk);
    check("err_rdy_hold", 32'(ByteReady), 32'd0);
    ByteValid = 1'b0;

    pulse_start();
    check("err_restart", 32'(Error), 32'd0);
    exp_q.push_back('{32'h0000_0000, 32'h8C09_0004});
    send_word(32'h0000_0001, 1'b0);
    send(8'h8C, 1'b0);
    send(8'h09, 1'b0);
    pulse_start();
    check("ign_start_hold", 32'(CpuHold), 32'd1);
    check("ign_start_rdy", 32'(ByteReady), 32'd1);
    check("ign_start_done", 32'(Done), 32'd0);
    send(8'h00, 1'b0);
    send(8'h04, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h8C09_0004, 1'b0);
`endif
    finish(1'b1, 1'b1);

    pulse_start();
    check("done_restart", 32'(Done), 32'd0);
    exp_q.push_back('{32'h0000_0000, 32'h1234_5678});
    send_word(32'h0000_0001, 1'b0);
    send_word(32'h1234_5678, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h1234_5678, 1'b0);
`endif
    finish(1'b1, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    exp_q.push_back('{32'h0000_0000, 32'h2008_0005});
    exp_q.push_back('{32'h0000_0004, 32'hAC08_0000});
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h2008_0005, 1'b0);
    send_word(32'hAC08_0000, 1'b0);
    send_word(32'hCC10_0006, 1'b0);
    finish(1'b0, 1'b1);
`endif

    pulse_start();
    send_word(32'h0000_0002, 1'b0);
    send(8'h20, 1'b0);
    send(8'h08, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("mid_rst_rdy", 32'(ByteReady), 32'd0);
    check("mid_rst_hold", 32'(CpuHold), 32'd0);
    check("mid_rst_wr", 32'(MemWrite), 32'd0);
    check("mid_rst_done", 32'(Done), 32'd0);
    check("mid_rst_err", 32'(Error), 32'd0);
    check("mid_rst_addr", WriteAddress, 32'd0);
    check("mid_rst_data", WriteData, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check("idle_rdy", 32'(ByteReady), 32'd0);
    check("idle_hold", 32'(CpuHold), 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
